// File: rtl/vx_fetch_unit_if.sv
// Bundle of the fetch unit's control strobes, icache request/response and decode-side channels.
// master = fetch unit, slave = surrounding core / icache / decode.
interface vx_fetch_unit_if #(
  parameter int NUM_WARPS = 4,
  parameter int ADDR_W    = 32
);
  localparam int WID_W = $clog2(NUM_WARPS);

  logic                 warp_act_valid;
  logic [NUM_WARPS-1:0] warp_act_mask;
  logic [ADDR_W-1:0]    warp_act_pc;
  logic                 wstall_valid;
  logic [WID_W-1:0]     wstall_wid;
  logic                 wstall_stalled;
  logic                 branch_valid;
  logic [WID_W-1:0]     branch_wid;
  logic                 branch_taken;
  logic [ADDR_W-1:0]    branch_dest;
  logic                 icache_req_valid;
  logic [ADDR_W-1:0]    icache_req_addr;
  logic [WID_W-1:0]     icache_req_tag;
  logic                 icache_req_ready;
  logic                 icache_rsp_valid;
  logic [31:0]          icache_rsp_data;
  logic [WID_W-1:0]     icache_rsp_tag;
  logic                 icache_rsp_ready;
  logic                 ifetch_rsp_valid;
  logic [WID_W-1:0]     ifetch_rsp_wid;
  logic [ADDR_W-1:0]    ifetch_rsp_pc;
  logic [31:0]          ifetch_rsp_instr;
  logic                 ifetch_rsp_ready;

  modport master (
    input  warp_act_valid, warp_act_mask, warp_act_pc,
    input  wstall_valid, wstall_wid, wstall_stalled,
    input  branch_valid, branch_wid, branch_taken, branch_dest,
    output icache_req_valid, icache_req_addr, icache_req_tag,
    input  icache_req_ready,
    input  icache_rsp_valid, icache_rsp_data, icache_rsp_tag,
    output icache_rsp_ready,
    output ifetch_rsp_valid, ifetch_rsp_wid, ifetch_rsp_pc, ifetch_rsp_instr,
    input  ifetch_rsp_ready
  );

  modport slave (
    output warp_act_valid, warp_act_mask, warp_act_pc,
    output wstall_valid, wstall_wid, wstall_stalled,
    output branch_valid, branch_wid, branch_taken, branch_dest,
    input  icache_req_valid, icache_req_addr, icache_req_tag,
    output icache_req_ready,
    output icache_rsp_valid, icache_rsp_data, icache_rsp_tag,
    input  icache_rsp_ready,
    input  ifetch_rsp_valid, ifetch_rsp_wid, ifetch_rsp_pc, ifetch_rsp_instr,
    output ifetch_rsp_ready
  );
endinterface

// File: rtl/vx_fetch_unit.sv
// Multi-warp instruction fetch: round-robin icache request issue with a credit cap,
// per-warp PC/stall tracking and a one-entry skid register toward decode.
module vx_fetch_unit #(
  parameter int                NUM_WARPS       = 4,
  parameter int                ADDR_W          = 32,
  parameter logic [ADDR_W-1:0] STARTUP_ADDR    = ADDR_W'(32'h8000_0000),
  parameter int                MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            reset,
  vx_fetch_unit_if.master bus,
  output logic            busy
);
  localparam int WID_W = $clog2(NUM_WARPS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [WID_W-1:0]  wid_t;
  typedef logic [ADDR_W-1:0] addr_t;

  addr_t                pc_q [NUM_WARPS];
  addr_t                pc_d [NUM_WARPS];
  addr_t                fpc_q [NUM_WARPS];
  addr_t                fpc_d [NUM_WARPS];
  logic [NUM_WARPS-1:0] active_q, active_d;
  logic [NUM_WARPS-1:0] stalled_q, stalled_d;
  logic [NUM_WARPS-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0]     outst_q, outst_d;
  wid_t                 last_q, last_d;
  logic                 hold_q, hold_d;
  wid_t                 hold_wid_q, hold_wid_d;
  logic                 rspv_q, rspv_d;
  wid_t                 rsp_wid_q, rsp_wid_d;
  addr_t                rsp_pc_q, rsp_pc_d;
  logic [31:0]          rsp_instr_q, rsp_instr_d;

  logic [NUM_WARPS-1:0] eligible;
  logic                 credit;
  logic                 sel_found;
  wid_t                 sel_wid;
  wid_t                 idx;
  logic                 hold_live;
  logic                 req_valid;
  wid_t                 req_wid;
  logic                 rsp_ready;
  logic                 req_fire;
  logic                 rsp_fire;
  logic                 rsp_hit;

  assign eligible  = active_q & ~stalled_q & ~inflight_q;
  assign credit    = (outst_q < CNT_W'(MAX_OUTSTANDING));
  // A stalled-by-backpressure request keeps its warp until accepted or that warp is deactivated.
  assign hold_live = hold_q & active_q[hold_wid_q];
  assign req_wid   = hold_live ? hold_wid_q : sel_wid;
  assign req_valid = ~reset & (hold_live | (sel_found & credit));
  assign rsp_ready = ~rspv_q | bus.ifetch_rsp_ready;
  assign req_fire  = req_valid & bus.icache_req_ready;
  assign rsp_fire  = bus.icache_rsp_valid & rsp_ready;
  assign rsp_hit   = rsp_fire & inflight_q[bus.icache_rsp_tag];

  assign bus.icache_req_valid = req_valid;
  assign bus.icache_req_addr  = pc_q[req_wid];
  assign bus.icache_req_tag   = req_wid;
  assign bus.icache_rsp_ready = rsp_ready;
  assign bus.ifetch_rsp_valid = rspv_q;
  assign bus.ifetch_rsp_wid   = rsp_wid_q;
  assign bus.ifetch_rsp_pc    = rsp_pc_q;
  assign bus.ifetch_rsp_instr = rsp_instr_q;
  assign busy = (|active_q) | (outst_q != CNT_W'(0)) | rspv_q;

  // Round-robin pick: first eligible warp searching upward from last issued + 1.
  always_comb begin
    sel_found = 1'b0;
    sel_wid   = last_q;
    idx       = last_q;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      idx = last_q + WID_W'(i);
      if (!sel_found && eligible[idx]) begin
        sel_found = 1'b1;
        sel_wid   = idx;
      end
    end
  end

  // Next-state: issue, response, then stall/branch/activation updates in rising priority.
  always_comb begin
    pc_d        = pc_q;
    fpc_d       = fpc_q;
    active_d    = active_q;
    stalled_d   = stalled_q;
    inflight_d  = inflight_q;
    last_d      = last_q;
    hold_d      = req_valid & ~bus.icache_req_ready;
    hold_wid_d  = req_wid;
    rspv_d      = rspv_q;
    rsp_wid_d   = rsp_wid_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_instr_d = rsp_instr_q;

    if (req_fire) begin
      inflight_d[req_wid] = 1'b1;
      stalled_d[req_wid]  = 1'b1;
      fpc_d[req_wid]      = pc_q[req_wid];
      pc_d[req_wid]       = pc_q[req_wid] + ADDR_W'(32'd4);
      last_d              = req_wid;
    end else begin
      last_d = last_q;
    end

    if (rsp_hit) begin
      inflight_d[bus.icache_rsp_tag] = 1'b0;
      rspv_d      = 1'b1;
      rsp_wid_d   = bus.icache_rsp_tag;
      rsp_pc_d    = fpc_q[bus.icache_rsp_tag];
      rsp_instr_d = bus.icache_rsp_data;
    end else if (bus.ifetch_rsp_ready) begin
      rspv_d = 1'b0;
    end else begin
      rspv_d = rspv_q;
    end

    if (bus.wstall_valid) begin
      stalled_d[bus.wstall_wid] = bus.wstall_stalled;
    end else begin
      stalled_d = stalled_d;
    end

    if (bus.branch_valid) begin
      stalled_d[bus.branch_wid] = 1'b0;
      if (bus.branch_taken) begin
        pc_d[bus.branch_wid] = bus.branch_dest;
      end else begin
        pc_d[bus.branch_wid] = pc_d[bus.branch_wid];
      end
    end else begin
      stalled_d = stalled_d;
    end

    if (bus.warp_act_valid) begin
      active_d = bus.warp_act_mask;
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (bus.warp_act_mask[w] && !active_q[w]) begin
          pc_d[w]      = bus.warp_act_pc;
          stalled_d[w] = 1'b0;
        end else begin
          stalled_d[w] = stalled_d[w];
        end
      end
    end else begin
      active_d = active_q;
    end

    case ({req_fire, rsp_hit})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        pc_q[w]  <= STARTUP_ADDR;
        fpc_q[w] <= '0;
      end
      active_q    <= NUM_WARPS'(1);
      stalled_q   <= '0;
      inflight_q  <= '0;
      outst_q     <= '0;
      last_q      <= WID_W'(NUM_WARPS - 1);
      hold_q      <= 1'b0;
      hold_wid_q  <= '0;
      rspv_q      <= 1'b0;
      rsp_wid_q   <= '0;
      rsp_pc_q    <= '0;
      rsp_instr_q <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      fpc_q       <= fpc_d;
      active_q    <= active_d;
      stalled_q   <= stalled_d;
      inflight_q  <= inflight_d;
      outst_q     <= outst_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      hold_wid_q  <= hold_wid_d;
      rspv_q      <= rspv_d;
      rsp_wid_q   <= rsp_wid_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_instr_q <= rsp_instr_d;
    end
  end
endmodule

// File: tb/tb_vx_fetch_unit.sv
// Scoreboard bench for vx_fetch_unit: directed scenarios followed by random traffic
// against a per-warp behavioural model; a separate monitor checks decode-side output.
module tb_vx_fetch_unit;
  localparam int NW = 4;
  localparam int AW = 32;
  localparam int MAXO = 4;
  localparam logic [31:0] START = 32'h8000_0000;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  vx_fetch_unit_if #(.NUM_WARPS(NW), .ADDR_W(AW)) bus ();

  vx_fetch_unit #(.NUM_WARPS(NW), .ADDR_W(AW), .STARTUP_ADDR(START), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic rdy;
    logic av; logic [3:0] am; logic [31:0] apc;
    logic wv; logic [1:0] ww; logic ws;
    logic bv; logic [1:0] bw; logic bt; logic [31:0] bd;
    logic rv; logic [1:0] rt; logic [31:0] rd;
    logic ir;
  } stim_t;

  typedef struct { logic [1:0] wid; logic [31:0] pc; logic [31:0] instr; } sb_ent_t;

  logic [31:0] m_pc [NW];
  logic [31:0] m_fpc [NW];
  logic [NW-1:0] m_act, m_stl, m_inf;
  int m_cnt, m_last, m_hwid;
  logic m_held;
  logic [NW-1:0] pend_v;
  logic [31:0] pend_d [NW];
  sb_ent_t sb[$];
  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int w = 0; w < NW; w++) m_pc[w] = START;
    m_act = 4'b0001; m_stl = '0; m_inf = '0;
    m_cnt = 0; m_last = NW - 1; m_held = 1'b0; m_hwid = 0;
  endfunction

  // Which warp should the fetch unit be presenting right now, if any.
  function automatic void predict(output logic v, output int t);
    v = 1'b0; t = 0;
    if (m_held && m_act[m_hwid]) begin
      v = 1'b1; t = m_hwid;
    end else if (m_cnt < MAXO) begin
      for (int i = 1; i <= NW; i++) begin
        int w;
        w = (m_last + i) % NW;
        if (!v && m_act[w] && !m_stl[w] && !m_inf[w]) begin v = 1'b1; t = w; end
      end
    end
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.rdy = 1'b0; s.av = 1'b0; s.am = 4'd0; s.apc = 32'd0;
    s.wv = 1'b0; s.ww = 2'd0; s.ws = 1'b0; s.bv = 1'b0; s.bw = 2'd0; s.bt = 1'b0; s.bd = 32'd0;
    s.rv = 1'b0; s.rt = 2'd0; s.rd = 32'd0; s.ir = 1'b1;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    reset = s.rst;
    bus.icache_req_ready = s.rdy;
    bus.warp_act_valid = s.av; bus.warp_act_mask = s.am; bus.warp_act_pc = s.apc;
    bus.wstall_valid = s.wv; bus.wstall_wid = s.ww; bus.wstall_stalled = s.ws;
    bus.branch_valid = s.bv; bus.branch_wid = s.bw; bus.branch_taken = s.bt; bus.branch_dest = s.bd;
    bus.icache_rsp_valid = s.rv; bus.icache_rsp_tag = s.rt; bus.icache_rsp_data = s.rd;
    bus.ifetch_rsp_ready = s.ir;
  endtask

  task automatic step(input stim_t s);
    logic ev; int et; logic exp_rr; logic fire; logic hit;
    @(negedge clk);
    predict(ev, et);
    drive(s);
    #1;
    if (s.rst) begin
      chk("rst_req_valid", bus.icache_req_valid, 1'b0);
      chk("rst_rsp_ready", bus.icache_rsp_ready, 1'b1);
      chk("rst_ifetch_valid", bus.ifetch_rsp_valid, 1'b0);
      chk("rst_busy", busy, 1'b1);
      model_reset();
      sb.delete();
      return;
    end
    chk("req_valid", bus.icache_req_valid, ev);
    if (ev && bus.icache_req_valid) begin
      chk("req_tag", bus.icache_req_tag, et[1:0]);
      chk("req_addr", bus.icache_req_addr, m_pc[et]);
    end
    exp_rr = (sb.size() == 0) || s.ir;
    chk("rsp_ready", bus.icache_rsp_ready, exp_rr);
    chk("ifetch_valid", bus.ifetch_rsp_valid, sb.size() != 0);
    chk("busy", busy, (|m_act) || (m_cnt != 0) || (sb.size() != 0));

    fire = ev && s.rdy;
    hit = s.rv && exp_rr && m_inf[s.rt];
    if (s.rv && exp_rr) pend_v[s.rt] = 1'b0;
    if (hit) begin
      sb.push_back('{wid: s.rt, pc: m_fpc[s.rt], instr: s.rd});
      m_inf[s.rt] = 1'b0;
      m_cnt--;
    end
    if (fire) begin
      m_inf[et] = 1'b1; m_stl[et] = 1'b1;
      m_fpc[et] = m_pc[et]; m_pc[et] = m_pc[et] + 32'd4;
      m_cnt++; m_last = et;
      pend_v[et] = 1'b1; pend_d[et] = $urandom;
    end
    m_held = ev && !s.rdy; m_hwid = et;
    if (s.wv) m_stl[s.ww] = s.ws;
    if (s.bv) begin
      m_stl[s.bw] = 1'b0;
      if (s.bt) m_pc[s.bw] = s.bd;
    end
    if (s.av) begin
      for (int w = 0; w < NW; w++)
        if (s.am[w] && !m_act[w]) begin m_pc[w] = s.apc; m_stl[w] = 1'b0; end
      m_act = s.am;
    end
  endtask

  function automatic stim_t rnd();
    stim_t s; logic ev; int et; int op; logic [1:0] w;
    s = idle();
    predict(ev, et);
    s.rdy = ($urandom_range(0, 3) != 0);
    s.ir = ($urandom_range(0, 3) != 0);
    op = $urandom_range(0, 15);
    w = 2'($urandom_range(0, NW - 1));
    if (op == 0) begin
      s.av = 1'b1; s.am = 4'($urandom_range(1, 15)); s.apc = $urandom & 32'hFFFF_FFFC;
    end else if (op <= 5 && !(ev && int'(w) == et)) begin
      s.wv = 1'b1; s.ww = w; s.ws = ($urandom_range(0, 3) == 0);
    end else if (op >= 6 && op <= 9 && !(ev && !s.rdy && int'(w) == et)) begin
      s.bv = 1'b1; s.bw = w; s.bt = $urandom_range(0, 1) == 1; s.bd = $urandom & 32'hFFFF_FFFC;
    end else if (op == 10 && !(ev && int'(w) == et)) begin
      s.wv = 1'b1; s.ww = w; s.ws = 1'b1;
      s.bv = 1'b1; s.bw = w; s.bt = 1'b1; s.bd = $urandom & 32'hFFFF_FFFC;
    end
    w = 2'($urandom_range(0, NW - 1));
    if ($urandom_range(0, 2) == 0) begin
      if (pend_v[w]) begin
        s.rv = 1'b1; s.rt = w; s.rd = pend_d[w];
      end else if ($urandom_range(0, 3) == 0) begin
        s.rv = 1'b1; s.rt = w; s.rd = $urandom;
      end
    end
    s.rst = ($urandom_range(0, 399) == 0);
    return s;
  endfunction

  // Decode-side monitor: every presented instruction must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset !== 1'b1 && bus.ifetch_rsp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL ifetch_unexpected: got wid %0d pc %h instr %h, expected none",
                   bus.ifetch_rsp_wid, bus.ifetch_rsp_pc, bus.ifetch_rsp_instr);
        end else begin
          chk("ifetch_wid", bus.ifetch_rsp_wid, sb[0].wid);
          chk("ifetch_pc", bus.ifetch_rsp_pc, sb[0].pc);
          chk("ifetch_instr", bus.ifetch_rsp_instr, sb[0].instr);
          if (bus.ifetch_rsp_ready === 1'b1) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    stim_t s;
    pend_v = '0;
    for (int w = 0; w < NW; w++) begin pend_d[w] = 32'd0; m_fpc[w] = 32'd0; end
    s = idle(); s.rst = 1'b1;
    drive(s);
    model_reset();
    step(s); step(s);

    s = idle(); s.rdy = 1'b1;
    repeat (3) step(s);
    s.av = 1'b1; s.am = 4'b1111; s.apc = 32'h0000_1000;
    step(s);
    s = idle(); s.rdy = 1'b1;
    repeat (5) step(s);

    s = idle(); s.rv = 1'b1; s.rt = 2'd2; s.rd = 32'hDEAD_BEEF; s.ir = 1'b0;
    step(s);
    s = idle(); s.ir = 1'b0; s.rv = 1'b1; s.rt = 2'd1; s.rd = pend_d[1];
    repeat (3) step(s);
    s = idle();
    step(s);
    s = idle(); s.rv = 1'b1; s.rt = 2'd2; s.rd = 32'h1234_5678;
    step(s);
    s = idle(); s.rv = 1'b1; s.rt = 2'd0; s.rd = pend_d[0];
    step(s);
    s = idle(); s.rdy = 1'b1;
    s.wv = 1'b1; s.ww = 2'd0; s.ws = 1'b0;
    s.bv = 1'b1; s.bw = 2'd0; s.bt = 1'b1; s.bd = 32'h0000_2000;
    step(s);
    s = idle(); s.rdy = 1'b1;
    repeat (3) step(s);
    s.wv = 1'b1; s.ww = 2'd2; s.ws = 1'b0;
    step(s);
    s = idle(); s.rdy = 1'b1;
    repeat (2) step(s);

    s = idle(); s.rst = 1'b1;
    step(s);
    s = idle(); s.rdy = 1'b1; s.rv = 1'b1; s.rt = 2'd1; s.rd = pend_d[1];
    step(s);
    s = idle(); s.rv = 1'b1; s.rt = 2'd3; s.rd = pend_d[3];
    repeat (2) step(s);

    for (int n = 0; n < 4000; n++) step(rnd());

    s = idle();
    repeat (4) step(s);
    @(negedge clk);
    #3;
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
